// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the channel multiplexer/arbiter.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-index width; never below one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_mux_arb_if.sv
// Producer-side and consumer-side stream bundle for chan_mux_arb.
interface chan_mux_arb_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8
) ();

    localparam int unsigned SEL_W = chan_mux_pkg::sel_w(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [SEL_W-1:0]         out_ch;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after i_last, wrapping.
module rr_arbiter
    import chan_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]             i_req,
    input  logic [sel_w(NUM_CH)-1:0]      i_last,
    input  logic                          i_en,
    output logic [NUM_CH-1:0]             o_gnt,
    output logic [sel_w(NUM_CH)-1:0]      o_gnt_idx,
    output logic                          o_any_gnt
);

    localparam int unsigned SEL_W = sel_w(NUM_CH);

    logic [SEL_W-1:0] w_cand;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    always_comb begin
        w_cand  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_cand = SEL_W'((32'(i_last) + k) % NUM_CH);
            if (i_en && !w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_any_gnt = w_found;
    assign o_gnt_idx = w_idx;
    assign o_gnt     = w_found ? (NUM_CH'(1) << w_idx) : '0;

endmodule

// File: rtl/chan_mux_arb.sv
// N-channel registered stream mux with fixed-select or round-robin grant.
module chan_mux_arb
    import chan_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_mux_arb_if.slave  bus
);

    localparam int unsigned SEL_W = sel_w(NUM_CH);

    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_last;

    logic              w_load_en;
    logic              w_fix_hit;
    logic              w_rr_any;
    logic [NUM_CH-1:0] w_rr_gnt;
    logic [SEL_W-1:0]  w_rr_idx;
    logic              w_any;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_xfer;
    logic [DATA_W-1:0] w_gnt_data;

    // Held in reset, nothing is readied even though the register is empty.
    assign w_load_en = rst_n & (~r_out_valid | bus.out_ready);

    // Out-of-range select never matches any channel.
    always_comb begin
        w_fix_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(bus.sel) == i && bus.in_valid[i]) begin
                w_fix_hit = 1'b1;
            end
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .i_req     (bus.in_valid),
        .i_last    (r_last),
        .i_en      (bus.mode == MODE_RR),
        .o_gnt     (w_rr_gnt),
        .o_gnt_idx (w_rr_idx),
        .o_any_gnt (w_rr_any)
    );

    always_comb begin
        if (bus.mode == MODE_RR) begin
            w_any     = w_rr_any;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_any     = w_fix_hit;
            w_gnt_idx = bus.sel;
        end
    end

    assign w_xfer       = w_load_en & w_any;
    assign w_gnt_data   = bus.in_data[32'(w_gnt_idx)*DATA_W +: DATA_W];
    assign bus.in_ready = w_xfer ? (NUM_CH'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_last      <= SEL_W'(NUM_CH - 1);
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_gnt_data;
                r_out_ch   <= w_gnt_idx;
                r_last     <= w_gnt_idx;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

    logic w_unused;
    assign w_unused = ^w_rr_gnt;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Randomised plus directed bench for chan_mux_arb against a transaction-level model.
module tb_chan_mux_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    chan_mux_arb_if #(.NUM_CH(N), .DATA_W(W)) bus ();

    chan_mux_arb #(
        .NUM_CH (N),
        .DATA_W (W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: contents of the output register and the last-granted channel.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_grant();
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (bus.in_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_last  = N - 1;
    endtask

    // Enter just after a rising edge with inputs set; leave 1 ns after the next edge.
    task automatic cycle();
        int         g;
        logic       le;
        logic [3:0] er;
        g  = model_grant();
        le = !m_valid || bus.out_ready;
        er = (le && g >= 0) ? 4'(1 << g) : 4'h0;
        @(negedge clk);
        check("in_ready", 32'(bus.in_ready), 32'(er));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_ch", 32'(bus.out_ch), 32'(m_ch));
        @(posedge clk);
        if (le) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*W +: W];
                m_ch    = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 4'hF;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset: nothing readied, register empty, ch0 wins first.
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        do_reset();
        #1;
        check("rst_first_rr", 32'(bus.in_ready), 32'h1);
        cycle();

        // Fixed select of ch2 with every channel valid.
        bus.mode    = 1'b0;
        bus.sel     = 2'd2;
        bus.in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        #1;
        check("fix_in_ready", 32'(bus.in_ready), 32'h4);
        cycle();
        check("fix_out_data", 32'(bus.out_data), 32'hA5);
        check("fix_out_ch", 32'(bus.out_ch), 2);
        cycle();

        // Round-robin with all valid after a fresh reset.
        do_reset();
        bus.mode    = 1'b1;
        bus.in_data = {8'd13, 8'd12, 8'd11, 8'd10};
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_seq_ch", 32'(bus.out_ch), 32'(i % N));
            check("rr_seq_data", 32'(bus.out_data), 32'(10 + i % N));
            check("rr_no_bubble", 32'(bus.out_valid), 1);
        end

        // Backpressure: load ch1, stall five cycles, then next word in same cycle.
        bus.mode     = 1'b0;
        bus.sel      = 2'd1;
        bus.in_valid = 4'b0010;
        bus.in_data  = {8'h00, 8'h00, 8'h3C, 8'h00};
        cycle();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        bus.in_data   = {8'h00, 8'h00, 8'h77, 8'h00};
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_hold", 32'(bus.out_data), 32'h3C);
            cycle();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release", 32'(bus.in_ready), 32'h2);
        cycle();
        check("bp_next", 32'(bus.out_data), 32'h77);

        // Sparse round-robin with wrap, pointer parked at 2.
        bus.sel      = 2'd2;
        bus.in_valid = 4'b0100;
        cycle();
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1010;
        cycle();
        check("sparse_0", 32'(bus.out_ch), 3);
        cycle();
        check("sparse_1", 32'(bus.out_ch), 1);
        cycle();
        check("sparse_2", 32'(bus.out_ch), 3);

        // Drain with no requester.
        bus.in_valid = 4'h0;
        cycle();
        check("drain", 32'(bus.out_valid), 0);

        // Asynchronous reset while holding a word from ch1.
        bus.mode     = 1'b0;
        bus.sel      = 2'd1;
        bus.in_valid = 4'b0010;
        cycle();
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(bus.out_valid), 0);
        do_reset();
        bus.out_ready = 1'b1;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'hF;
        cycle();
        check("rst_prio", 32'(bus.out_ch), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.mode      = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 32'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
